// File: rtl/ram_block_mover.sv
// ram_block_mover: bus-master block engine for a single-port 16K x 16 RAM.
// Each operation either copies a block of words from src to dst, or fills a block at dst with a constant.
// A copy takes two cycles per word: a read cycle followed by a write cycle.
// A fill takes one cycle per word, because it only writes.
// Pointers wrap modulo 2**ADDR_W.
module ram_block_mover #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              fill,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [DATA_W-1:0] fill_value,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_load,
  output logic [DATA_W-1:0] mem_in_value,
  input  logic [DATA_W-1:0] mem_out
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   src_q;
  logic [ADDR_W-1:0]   dst_q;
  logic [CNT_W-1:0]    rem_q;
  logic                fill_q;
  logic [DATA_W-1:0]   fval_q;

  // Sequencer: accepts a request in IDLE/DONE, then alternates RD/WR (copy) or streams WR (fill).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      fill_q  <= 1'b0;
      fval_q  <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            src_q  <= src_addr;
            dst_q  <= dst_addr;
            rem_q  <= length;
            fill_q <= fill;
            fval_q <= fill_value;
            if (length == '0) begin
              state_q <= DONE;
            end else if (fill) begin
              state_q <= WR;
            end else begin
              state_q <= RD;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        RD: begin
          state_q <= WR;
        end
        WR: begin
          src_q <= src_q + PTR_ONE;
          dst_q <= dst_q + PTR_ONE;
          rem_q <= rem_q - CNT_ONE;
          if (rem_q == CNT_ONE) begin
            state_q <= DONE;
          end else if (fill_q) begin
            state_q <= WR;
          end else begin
            state_q <= RD;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // RAM port decode.
  // The RAM writes on every edge where mem_load is low, so mem_load is low only in WR.
  // In a copy, mem_in_value passes through the word read in the preceding RD cycle.
  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    mem_load     = 1'b1;
    mem_address  = '0;
    mem_in_value = '0;
    case (state_q)
      RD: begin
        busy        = 1'b1;
        mem_address = src_q;
      end
      WR: begin
        busy         = 1'b1;
        mem_load     = 1'b0;
        mem_address  = dst_q;
        mem_in_value = fill_q ? fval_q : mem_out;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule
